i2c_csr_bank: RTL and testbench



---
 rtl/i2c_csr_pkg.sv | 56 +++++
 rtl/i2c_csr_fifo.sv | 55 +++++
 rtl/i2c_csr_bank.sv | 192 +++++++++++++++++++
 tb/tb_i2c_csr_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_csr_pkg.sv
// Shared constants and register layout for the I2C CSR bank.
package i2c_csr_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned IRQ_W  = 5;

  localparam logic [ADDR_W-1:0] ADDR_CONTROL    = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE   = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_TX_DATA    = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_RX_DATA    = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_STATUS     = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_PARAM      = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_EN     = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_STATUS = 4'd7;

  localparam int unsigned CTRL_CORE_RST = 0;
  localparam int unsigned CTRL_CORE_EN  = 1;
  localparam int unsigned CTRL_RW       = 2;

  localparam int unsigned ST_AL         = 0;
  localparam int unsigned ST_BUSY       = 1;
  localparam int unsigned ST_RX_ACK     = 2;
  localparam int unsigned ST_TX_FULL    = 3;
  localparam int unsigned ST_RX_FULL    = 4;
  localparam int unsigned ST_TX_EMPTY   = 5;
  localparam int unsigned ST_RX_EMPTY   = 6;
  localparam int unsigned ST_TX_LVL_LSB = 8;
  localparam int unsigned ST_RX_LVL_LSB = 16;

  localparam int unsigned IRQ_AL         = 0;
  localparam int unsigned IRQ_TX_DRAINED = 1;
  localparam int unsigned IRQ_RX_PUSH    = 2;
  localparam int unsigned IRQ_TX_OVF     = 3;
  localparam int unsigned IRQ_RX_UDF     = 4;

  // CONTROL word, LSB first: core_rst, core_en, rw
  typedef struct packed {
    logic rw;
    logic core_en;
    logic core_rst;
  } ctrl_t;

  // Writable register state, sized for the widest configuration
  typedef struct packed {
    logic [IRQ_W-1:0] irq_en;
    logic [15:0]      prescale;
    ctrl_t            ctrl;
  } csr_regs_t;

  localparam csr_regs_t REG_INIT = '{
    irq_en:   '0,
    prescale: '0,
    ctrl:     '{rw: 1'b0, core_en: 1'b0, core_rst: 1'b1}
  };

endpackage

// File: rtl/i2c_csr_fifo.sv
// First-word-fall-through FIFO with level output and synchronous flush.
module i2c_csr_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [DATA_WIDTH-1:0]  push_data_i,
  input  logic                   pop_i,
  output logic [DATA_WIDTH-1:0]  head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [LEVEL_WIDTH-1:0] level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [LEVEL_WIDTH-1:0] count;
  logic                   do_pop;
  logic                   do_push;

  assign full_o  = (count == LEVEL_WIDTH'(FIFO_DEPTH));
  assign empty_o = (count == '0);
  assign level_o = count;
  assign head_o  = mem[rd_ptr];

  // A pop frees a slot, so push-while-full is accepted when paired with a pop
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + LEVEL_WIDTH'(do_push) - LEVEL_WIDTH'(do_pop);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/i2c_csr_bank.sv
// CPU-facing CSR bank for the I2C master: register decode, TX/RX FIFOs, IRQs.
module i2c_csr_bank
  import i2c_csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [3:0]                req_addr_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [DATA_WIDTH-1:0]     tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  input  logic [DATA_WIDTH-1:0]     rx_data_i,
  input  logic                      rx_valid_i,
  output logic                      rx_ready_o,
  input  logic                      core_busy_i,
  input  logic                      core_rx_ack_i,
  input  logic                      core_al_i,
  output logic                      core_en_o,
  output logic                      core_rst_o,
  output logic                      rw_o,
  output logic [PRESCALE_WIDTH-1:0] prescale_o,
  output logic                      irq_o
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  csr_regs_t          regs;
  logic [IRQ_W-1:0]   irq_sts;
  logic [IRQ_W-1:0]   irq_sts_d;
  logic [IRQ_W-1:0]   irq_set;
  logic               tx_empty_q;

  logic               acc;
  logic [31:0]        rd_c;
  logic               err_c;
  logic               ctrl_we, pre_we, en_we;
  logic [IRQ_W-1:0]   w1c_c;
  logic               tx_push_c, rx_pop_c, ovf_c, udf_c;
  logic [31:0]        status_c;
  logic [31:0]        param_c;

  logic [DATA_WIDTH-1:0] tx_head, rx_head;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [LW-1:0]         tx_level, rx_level;
  logic                  unused_bits;

  assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
  assign acc         = req_valid_i & req_ready_o & ~rst_i;

  assign core_rst_o  = regs.ctrl.core_rst;
  assign core_en_o   = regs.ctrl.core_en & ~regs.ctrl.core_rst;
  assign rw_o        = regs.ctrl.rw;
  assign prescale_o  = regs.prescale[PRESCALE_WIDTH-1:0];
  assign tx_valid_o  = ~tx_empty;
  assign tx_data_o   = tx_empty ? '0 : tx_head;
  assign rx_ready_o  = ~rx_full;
  assign unused_bits = ^{req_wdata_i, regs.prescale};

  i2c_csr_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .LEVEL_WIDTH(LW)) u_tx_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (regs.ctrl.core_rst),
    .push_i      (tx_push_c),
    .push_data_i (req_wdata_i[DATA_WIDTH-1:0]),
    .pop_i       (tx_ready_i),
    .head_o      (tx_head),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .level_o     (tx_level)
  );

  i2c_csr_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .LEVEL_WIDTH(LW)) u_rx_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (regs.ctrl.core_rst),
    .push_i      (rx_valid_i),
    .push_data_i (rx_data_i),
    .pop_i       (rx_pop_c),
    .head_o      (rx_head),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .level_o     (rx_level)
  );

  // Read-only views: STATUS and PARAM words
  always_comb begin
    status_c                          = '0;
    status_c[ST_AL]                   = irq_sts[IRQ_AL];
    status_c[ST_BUSY]                 = core_busy_i;
    status_c[ST_RX_ACK]               = core_rx_ack_i;
    status_c[ST_TX_FULL]              = tx_full;
    status_c[ST_RX_FULL]              = rx_full;
    status_c[ST_TX_EMPTY]             = tx_empty;
    status_c[ST_RX_EMPTY]             = rx_empty;
    status_c[ST_TX_LVL_LSB +: 8]      = 8'(tx_level);
    status_c[ST_RX_LVL_LSB +: 8]      = 8'(rx_level);
    param_c = {8'd0, 8'(FIFO_DEPTH), 8'd8, 8'(DATA_WIDTH)};
  end

  // Access decode: read mux, write strobes, FIFO side effects and errors
  always_comb begin
    rd_c      = '0;
    err_c     = 1'b0;
    ctrl_we   = 1'b0;
    pre_we    = 1'b0;
    en_we     = 1'b0;
    w1c_c     = '0;
    tx_push_c = 1'b0;
    rx_pop_c  = 1'b0;
    ovf_c     = 1'b0;
    udf_c     = 1'b0;
    if (acc) begin
      case (req_addr_i)
        ADDR_CONTROL:    if (req_write_i) ctrl_we = 1'b1; else rd_c = 32'(regs.ctrl);
        ADDR_PRESCALE:   if (req_write_i) pre_we = 1'b1; else rd_c = 32'(regs.prescale);
        ADDR_TX_DATA: begin
          if (!req_write_i) err_c = 1'b1;
          else if (tx_full) begin
            err_c = 1'b1;
            ovf_c = 1'b1;
          end else if (regs.ctrl.core_rst) err_c = 1'b1;
          else tx_push_c = 1'b1;
        end
        ADDR_RX_DATA: begin
          if (req_write_i) err_c = 1'b1;
          else if (rx_empty) begin
            err_c = 1'b1;
            udf_c = 1'b1;
          end else begin
            rx_pop_c = 1'b1;
            rd_c     = 32'(rx_head);
          end
        end
        ADDR_STATUS:     if (req_write_i) err_c = 1'b1; else rd_c = status_c;
        ADDR_PARAM:      if (req_write_i) err_c = 1'b1; else rd_c = param_c;
        ADDR_IRQ_EN:     if (req_write_i) en_we = 1'b1; else rd_c = 32'(regs.irq_en);
        ADDR_IRQ_STATUS: if (req_write_i) w1c_c = req_wdata_i[IRQ_W-1:0]; else rd_c = 32'(irq_sts);
        default:         err_c = 1'b1;
      endcase
    end
  end

  // Sticky interrupt sources; a same-cycle set overrides the clear
  always_comb begin
    irq_set                 = '0;
    irq_set[IRQ_AL]         = core_al_i;
    irq_set[IRQ_TX_DRAINED] = tx_empty & ~tx_empty_q;
    irq_set[IRQ_RX_PUSH]    = rx_valid_i & ~rx_full & ~regs.ctrl.core_rst;
    irq_set[IRQ_TX_OVF]     = ovf_c;
    irq_set[IRQ_RX_UDF]     = udf_c;
    irq_sts_d               = (irq_sts & ~w1c_c) | irq_set;
  end

  // Register state, interrupt line and response channel
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs        <= REG_INIT;
      irq_sts     <= '0;
      irq_o       <= 1'b0;
      tx_empty_q  <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (ctrl_we) regs.ctrl     <= ctrl_t'(req_wdata_i[2:0]);
      if (pre_we)  regs.prescale <= 16'(req_wdata_i[PRESCALE_WIDTH-1:0]);
      if (en_we)   regs.irq_en   <= req_wdata_i[IRQ_W-1:0];
      irq_sts    <= irq_sts_d;
      irq_o      <= |(irq_sts_d & regs.irq_en);
      tx_empty_q <= tx_empty;
      if (acc) begin
        rsp_valid_o <= 1'b1;
        rsp_rdata_o <= rd_c;
        rsp_err_o   <= err_c;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_csr_bank.sv
// Directed self-checking bench for i2c_csr_bank.
module tb_i2c_csr_bank;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [3:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [7:0]  tx_data_o, rx_data_i;
  logic        tx_valid_o, tx_ready_i, rx_valid_i, rx_ready_o;
  logic        core_busy_i, core_rx_ack_i, core_al_i;
  logic        core_en_o, core_rst_o, rw_o, irq_o;
  logic [15:0] prescale_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2c_csr_bank #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .PRESCALE_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .core_busy_i(core_busy_i), .core_rx_ack_i(core_rx_ack_i), .core_al_i(core_al_i),
    .core_en_o(core_en_o), .core_rst_o(core_rst_o), .rw_o(rw_o),
    .prescale_o(prescale_o), .irq_o(irq_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus access with rsp_ready held high; returns the response fields
  task automatic bus(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                     input logic al, output logic [31:0] rd, output logic er);
    int   n;
    logic got;
    @(negedge clk);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_wdata_i = wd; core_al_i = al;
    n = 0;
    while (!req_ready_o && n < 8) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0; core_al_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin @(negedge clk); got = rsp_valid_o; end
    check("rsp_valid", 32'(got), 32'd1);
    rd = rsp_rdata_o;
    er = rsp_err_o;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] addr,
                        input logic [31:0] exp, input logic exp_err);
    logic [31:0] d; logic e;
    bus(1'b0, addr, 32'd0, 1'b0, d, e);
    check({tag, "_data"}, d, exp);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  task automatic wr_chk(input string tag, input logic [3:0] addr,
                        input logic [31:0] wd, input logic exp_err);
    logic [31:0] d; logic e;
    bus(1'b1, addr, wd, 1'b0, d, e);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          beats;
    int          bad_order;
    logic [31:0] held;

    rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    rsp_ready_i = 1'b1; tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0;
    core_busy_i = 1'b0; core_rx_ack_i = 1'b0; core_al_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_core_rst", 32'(core_rst_o), 32'd1);
    check("rst_core_en", 32'(core_en_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    rd_chk("rst_status", 4'd4, 32'h0000_0060, 1'b0);
    rd_chk("rst_control", 4'd0, 32'h0000_0001, 1'b0);
    rd_chk("rst_param", 4'd5, 32'h0010_0808, 1'b0);

    // Control and prescale
    wr_chk("wr_control", 4'd0, 32'h2, 1'b0);
    check("core_en_on", 32'(core_en_o), 32'd1);
    check("core_rst_off", 32'(core_rst_o), 32'd0);
    wr_chk("wr_prescale", 4'd1, 32'h0001_2345, 1'b0);
    check("prescale_out", 32'(prescale_o), 32'h2345);
    rd_chk("rd_prescale", 4'd1, 32'h0000_2345, 1'b0);

    // Fill TX to capacity, then overflow
    for (int i = 0; i < 16; i++) begin
      bus(1'b1, 4'd2, 32'h10 + 32'(i), 1'b0, d, e);
      if (e !== 1'b0) check("tx_push_err", 32'(e), 32'd0);
    end
    check("tx_valid_fill", 32'(tx_valid_o), 32'd1);
    check("tx_head", 32'(tx_data_o), 32'h10);
    wr_chk("tx_overflow", 4'd2, 32'hFF, 1'b1);
    rd_chk("irq_after_ovf", 4'd7, 32'h08, 1'b0);
    rd_chk("status_full", 4'd4, 32'h0000_1048, 1'b0);

    // Drain TX with drain interrupt enabled
    wr_chk("wr_irq_en", 4'd6, 32'h02, 1'b0);
    check("irq_masked", 32'(irq_o), 32'd0);
    @(negedge clk);
    tx_ready_i = 1'b1;
    beats = 0; bad_order = 0;
    while (tx_valid_o && beats < 40) begin
      if (tx_data_o !== 8'(8'h10 + beats)) bad_order++;
      beats++;
      @(negedge clk);
    end
    tx_ready_i = 1'b0;
    check("drain_beats", 32'(beats), 32'd16);
    check("drain_order", 32'(bad_order), 32'd0);
    check("irq_not_yet", 32'(irq_o), 32'd0);
    @(negedge clk);
    check("irq_drained", 32'(irq_o), 32'd1);
    wr_chk("w1c_drained", 4'd7, 32'h02, 1'b0);
    check("irq_cleared", 32'(irq_o), 32'd0);
    rd_chk("irq_sts_after_w1c", 4'd7, 32'h08, 1'b0);

    // RX underflow, then a real receive
    rd_chk("rx_underflow", 4'd3, 32'h0, 1'b1);
    rd_chk("irq_after_udf", 4'd7, 32'h18, 1'b0);
    @(negedge clk);
    rx_data_i = 8'hA5; rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
    rd_chk("rx_pop", 4'd3, 32'h0000_00A5, 1'b0);
    rd_chk("irq_after_rx", 4'd7, 32'h1C, 1'b0);

    // Access errors
    wr_chk("wr_status_ro", 4'd4, 32'hFFFF_FFFF, 1'b1);
    rd_chk("rd_addr9", 4'd9, 32'h0, 1'b1);
    rd_chk("rd_tx_data", 4'd2, 32'h0, 1'b1);
    rd_chk("status_unchanged", 4'd4, 32'h0000_0060, 1'b0);

    // Arbitration lost coinciding with W1C: set wins
    wr_chk("w1c_all", 4'd7, 32'h1F, 1'b0);
    rd_chk("irq_zero", 4'd7, 32'h0, 1'b0);
    bus(1'b1, 4'd7, 32'h01, 1'b1, d, e);
    check("al_w1c_err", 32'(e), 32'd0);
    rd_chk("status_al", 4'd4, 32'h0000_0061, 1'b0);
    wr_chk("w1c_al", 4'd7, 32'h01, 1'b0);
    rd_chk("irq_al_clear", 4'd7, 32'h0, 1'b0);

    // Response stall, then reset mid-stall
    @(negedge clk);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 4'd0;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    check("stall_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("stall_rdata", rsp_rdata_o, 32'h2);
    held = rsp_rdata_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready_low", 32'(req_ready_o), 32'd0);
      check("stall_rdata_hold", rsp_rdata_o, held);
    end
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_drop_rsp", 32'(rsp_valid_o), 32'd0);
    check("rst_core_rst_again", 32'(core_rst_o), 32'd1);
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    rd_chk("control_after_rst", 4'd0, 32'h1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
